// File: rtl/multiplier_share_arbiter.sv
// Round-robin scheduler sharing one sequential multiplier among NUM_REQ requesters.
// IDLE->ISSUE->WAIT->RESP; a watchdog aborts a hung multiply, and taint is propagated to result_t.
module multiplier_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ-1:0]       i_req_t,
  input  logic [NUM_REQ*WIDTH-1:0] i_opa,
  input  logic [NUM_REQ*WIDTH-1:0] i_opb,
  input  logic [NUM_REQ-1:0]       i_op_t,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [2*WIDTH-1:0]       o_result,
  output logic                     o_result_t,
  output logic                     o_err,
  output logic                     o_busy,
  output logic                     o_mul_start,
  output logic                     o_mul_start_t,
  output logic [WIDTH-1:0]         o_mul_a,
  output logic [WIDTH-1:0]         o_mul_b,
  output logic                     o_mul_op_t,
  input  logic                     i_mul_done,
  input  logic                     i_mul_done_t,
  input  logic [2*WIDTH-1:0]       i_mul_product,
  input  logic                     i_mul_product_t
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [IDXW-1:0]     r_last, r_owner;
  logic [WIDTH-1:0]    r_a, r_b;
  logic                r_op_t, r_grant_t;
  logic [WDW-1:0]      r_wdog;
  logic [2*WIDTH-1:0]  r_res;
  logic                r_res_t, r_err;
  logic [IDXW-1:0]     w_pick, w_idx;
  logic                w_any;
  logic                w_expire;

  // First requester after the last owner, with wrap-around.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDXW'((int'(r_last) + k) % NUM_REQ);
      if (!w_any && i_req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_expire = (r_wdog == WD_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    o_ack         = '0;
    o_done        = '0;
    o_result      = '0;
    o_result_t    = 1'b0;
    o_err         = 1'b0;
    o_mul_start   = 1'b0;
    o_mul_start_t = 1'b0;
    o_busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: begin
        o_ack[r_owner] = 1'b1;
        o_mul_start    = 1'b1;
        o_mul_start_t  = r_grant_t | i_req_t[r_owner];
        w_next         = S_WAIT;
      end
      S_WAIT:  if (i_mul_done || w_expire) w_next = S_RESP;
      S_RESP: begin
        o_done[r_owner] = 1'b1;
        o_result        = r_res;
        o_result_t      = r_res_t;
        o_err           = r_err;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last    <= IDXW'(NUM_REQ - 1);
      r_owner   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op_t    <= 1'b0;
      r_grant_t <= 1'b0;
      r_wdog    <= '0;
      r_res     <= '0;
      r_res_t   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_owner   <= w_pick;
          r_a       <= i_opa[w_pick*WIDTH +: WIDTH];
          r_b       <= i_opb[w_pick*WIDTH +: WIDTH];
          r_op_t    <= i_op_t[w_pick];
          // Who won depends on every contender, so any tainted request taints the grant.
          r_grant_t <= |i_req_t;
        end
        S_ISSUE: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= r_wdog + WDW'(1);
          if (i_mul_done) begin
            r_res   <= i_mul_product;
            r_res_t <= i_mul_product_t | i_mul_done_t | r_grant_t | r_op_t;
            r_err   <= 1'b0;
          end else if (w_expire) begin
            r_res   <= '0;
            r_res_t <= r_grant_t;
            r_err   <= 1'b1;
          end
        end
        S_RESP: r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign o_mul_a    = r_a;
  assign o_mul_b    = r_b;
  assign o_mul_op_t = r_op_t;

endmodule

// File: tb/tb_multiplier_share_arbiter.sv
// Bench for multiplier_share_arbiter: directed table, reset/stale-done sequence, randomized jobs
// checked against a round-robin reference model, plus a pulse/quiet-output monitor.
module tb_multiplier_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_req, i_req_t, i_op_t;
  logic [N*W-1:0] i_opa, i_opb;
  logic [N-1:0]   o_ack, o_done;
  logic [2*W-1:0] o_result;
  logic           o_result_t, o_err, o_busy, o_mul_start, o_mul_start_t, o_mul_op_t;
  logic [W-1:0]   o_mul_a, o_mul_b;
  logic           i_mul_done, i_mul_done_t, i_mul_product_t;
  logic [2*W-1:0] i_mul_product;

  always #5 clk = ~clk;

  multiplier_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_t(i_req_t),
    .i_opa(i_opa), .i_opb(i_opb), .i_op_t(i_op_t),
    .o_ack(o_ack), .o_done(o_done), .o_result(o_result), .o_result_t(o_result_t),
    .o_err(o_err), .o_busy(o_busy), .o_mul_start(o_mul_start), .o_mul_start_t(o_mul_start_t),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_op_t(o_mul_op_t),
    .i_mul_done(i_mul_done), .i_mul_done_t(i_mul_done_t),
    .i_mul_product(i_mul_product), .i_mul_product_t(i_mul_product_t)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Multiplier model: answers mdl_delay cycles after a start (never if mdl_delay <= 0).
  int         mdl_delay = 10;
  logic       mdl_pt = 1'b0, mdl_dt = 1'b0;
  int         m_cnt = 0;
  logic       m_act = 1'b0;
  logic [W-1:0] m_a, m_b;

  always @(negedge clk) begin
    i_mul_done      = 1'b0;
    i_mul_done_t    = 1'b0;
    i_mul_product_t = 1'b0;
    i_mul_product   = '0;
    if (m_act) begin
      m_cnt--;
      if (m_cnt == 0) begin
        i_mul_done      = 1'b1;
        i_mul_done_t    = mdl_dt;
        i_mul_product_t = mdl_pt;
        i_mul_product   = (2*W)'(m_a * m_b);
        m_act           = 1'b0;
      end
    end
    if (o_mul_start) begin
      m_a   = o_mul_a;
      m_b   = o_mul_b;
      m_act = (mdl_delay > 0);
      m_cnt = mdl_delay;
    end
  end

  // Pulse and quiet-output monitor.
  logic prev_done = 1'b0, prev_ack = 1'b0, prev_start = 1'b0;
  always @(negedge clk) begin
    if (i_rst) begin
      if (o_done != 0 || o_ack != 0)
        chk("pulse_shape",
            int'($countones(o_done) > 1 || $countones(o_ack) > 1 ||
                 (o_done != 0 && prev_done) || (o_ack != 0 && prev_ack) ||
                 (o_mul_start && prev_start)), 0);
      if (o_done == 0)
        chk("quiet_result", int'({o_result, o_result_t, o_err}), 0);
    end
    prev_done  = (o_done != 0);
    prev_ack   = (o_ack != 0);
    prev_start = o_mul_start;
  end

  logic [W-1:0] a [N];
  logic [W-1:0] b [N];

  typedef struct {
    logic [N-1:0] req, req_t, op_t;
    logic         hold, pt, dt;
    int           delay;
    int           own;
    logic         err, st, rt;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] req, req_t, op_t, input logic hold, pt, dt,
                              input int delay, own, input logic err, st, rt);
    vec_t v;
    v.req = req; v.req_t = req_t; v.op_t = op_t; v.hold = hold; v.pt = pt; v.dt = dt;
    v.delay = delay; v.own = own; v.err = err; v.st = st; v.rt = rt;
    return v;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: first set bit after the previous owner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic run_vec(input vec_t v, input string tag, output int ackw);
    int   own, gap, exp_res, exp_gap;
    logic got;
    i_opa     = {a[3], a[2], a[1], a[0]};
    i_opb     = {b[3], b[2], b[1], b[0]};
    i_req     = v.req;
    i_req_t   = v.req_t;
    i_op_t    = v.op_t;
    mdl_delay = v.delay;
    mdl_pt    = v.pt;
    mdl_dt    = v.dt;
    got = 1'b0; own = -1; ackw = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      ackw++;
      if (o_ack != 0) begin
        got = 1'b1;
        own = oh_idx(o_ack);
        chk({tag, ".owner"}, own, v.own);
        chk({tag, ".start"}, int'(o_mul_start), 1);
        chk({tag, ".start_t"}, int'(o_mul_start_t), int'(v.st));
        if (!v.hold) i_req[own] = 1'b0;
      end
    end
    if (!got) begin
      chk({tag, ".ack_timeout"}, 1, 0);
      i_req = '0;
      return;
    end
    exp_res = v.err ? 0 : int'(a[v.own]) * int'(b[v.own]);
    exp_gap = (v.delay <= 0 || v.delay > 32) ? 33 : v.delay + 1;
    got = 1'b0; gap = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      gap++;
      if (o_done != 0) begin
        got = 1'b1;
        chk({tag, ".done"}, int'(o_done), 1 << v.own);
        chk({tag, ".result"}, int'(o_result), exp_res);
        chk({tag, ".err"}, int'(o_err), int'(v.err));
        chk({tag, ".result_t"}, int'(o_result_t), int'(v.rt));
        chk({tag, ".gap"}, gap, exp_gap);
        if (!v.hold) i_req = '0;
      end
    end
    if (!got) begin
      chk({tag, ".done_timeout"}, 1, 0);
      i_req = '0;
    end
  endtask

  vec_t tbl [17];
  int   ackw;
  int   last_m;
  logic quiet;
  logic got_ack;
  vec_t rv;
  int   cyc;

  initial begin
    i_rst = 1'b0;
    i_req = '0; i_req_t = '0; i_op_t = '0; i_opa = '0; i_opb = '0;
    a[0] = 4'd3; a[1] = 4'd6; a[2] = 4'd9;  a[3] = 4'd15;
    b[0] = 4'd5; b[1] = 4'd7; b[2] = 4'd11; b[3] = 4'd14;

    //          req      req_t    op_t     hold pt dt  dly own err st rt
    tbl[0]  = mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0,  3, 0, 0, 0, 0);
    tbl[1]  = mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0,  3, 1, 0, 0, 0);
    tbl[2]  = mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0,  3, 2, 0, 0, 0);
    tbl[3]  = mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0,  3, 3, 0, 0, 0);
    tbl[4]  = mk(4'b1111, 4'b0000, 4'b0000, 1, 0, 0,  3, 0, 0, 0, 0);
    tbl[5]  = mk(4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 10, 0, 0, 0, 0);
    tbl[6]  = mk(4'b0010, 4'b0000, 4'b0000, 0, 0, 0, -1, 1, 1, 0, 0);
    tbl[7]  = mk(4'b0100, 4'b0000, 4'b0000, 0, 0, 0,  5, 2, 0, 0, 0);
    tbl[8]  = mk(4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 32, 3, 0, 0, 0);
    tbl[9]  = mk(4'b0011, 4'b0100, 4'b0000, 0, 0, 0,  4, 0, 0, 1, 1);
    tbl[10] = mk(4'b0010, 4'b0000, 4'b0000, 0, 0, 0,  4, 1, 0, 0, 0);
    tbl[11] = mk(4'b0100, 4'b0000, 4'b0100, 0, 0, 0,  4, 2, 0, 0, 1);
    tbl[12] = mk(4'b1000, 4'b0000, 4'b0001, 0, 0, 0,  4, 3, 0, 0, 0);
    tbl[13] = mk(4'b0001, 4'b0000, 4'b0000, 0, 1, 0,  4, 0, 0, 0, 1);
    tbl[14] = mk(4'b1001, 4'b0000, 4'b0000, 0, 0, 0,  4, 3, 0, 0, 0);
    tbl[15] = mk(4'b0110, 4'b0000, 4'b0000, 0, 0, 1,  4, 1, 0, 0, 1);
    tbl[16] = mk(4'b0100, 4'b1000, 4'b0000, 0, 0, 0, -1, 2, 1, 1, 1);

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({o_ack, o_done, o_result, o_result_t, o_err, o_busy, o_mul_start,
                               o_mul_start_t, o_mul_a, o_mul_b, o_mul_op_t}), 0);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("row%0d", i), ackw);

    // Reset in the middle of WAIT, then a stale mul_done arrives while idle.
    repeat (3) @(negedge clk);
    i_opa = {a[3], a[2], a[1], a[0]};
    i_opb = {b[3], b[2], b[1], b[0]};
    i_req = 4'b0100; i_req_t = '0; i_op_t = '0;
    mdl_delay = 20; mdl_pt = 1'b0; mdl_dt = 1'b0;
    got_ack = 1'b0;
    for (cyc = 0; cyc < 10 && !got_ack; cyc++) begin
      @(negedge clk);
      if (o_ack != 0) got_ack = 1'b1;
    end
    chk("rst_seq.ack_seen", int'(got_ack), 1);
    i_req = '0;
    repeat (5) @(negedge clk);
    #2 i_rst = 1'b0;
    #1 chk("rst_seq.async_clear", int'({o_ack, o_done, o_result, o_result_t, o_err, o_busy,
                                       o_mul_start, o_mul_start_t, o_mul_a, o_mul_b, o_mul_op_t}), 0);
    @(negedge clk);
    i_rst = 1'b1;
    quiet = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (o_done != 0 || o_busy) quiet = 1'b1;
    end
    chk("rst_seq.stale_done_ignored", int'(quiet), 0);
    a[0] = 4'd3; b[0] = 4'd5;
    run_vec(mk(4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 10, 0, 0, 0, 0), "post_rst", ackw);
    chk("post_rst.ack_latency", ackw, 1);

    // Randomized jobs against the reference model.
    last_m = 0;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = W'($urandom_range(0, 15));
        b[i] = W'($urandom_range(0, 15));
      end
      rv.req   = N'($urandom_range(1, 15));
      rv.req_t = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      rv.op_t  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      rv.pt    = ($urandom_range(0, 5) == 0);
      rv.dt    = ($urandom_range(0, 5) == 0);
      rv.hold  = 1'b0;
      rv.delay = $urandom_range(1, 12);
      rv.own   = rr_pick(rv.req, last_m);
      rv.err   = 1'b0;
      rv.st    = |rv.req_t;
      rv.rt    = (|rv.req_t) | rv.op_t[rv.own] | rv.pt | rv.dt;
      last_m   = rv.own;
      run_vec(rv, $sformatf("rnd%0d", j), ackw);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
